// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and memory.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

interface mem_arbiter_if #(
    parameter int unsigned XLEN = 32
) ();
    // Cache requests
    logic [1:0]      Icache2mem_command;
    logic [XLEN-1:0] Icache2mem_addr;
    logic [1:0]      Dcache2mem_command;
    logic [XLEN-1:0] Dcache2mem_addr;
    logic [63:0]     Dcache2mem_data;
    // Memory side
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    // Routed responses
    logic [3:0]      mem2Icache_response;
    logic [63:0]     mem2Icache_data;
    logic [3:0]      mem2Icache_tag;
    logic [3:0]      mem2Dcache_response;
    logic [63:0]     mem2Dcache_data;
    logic [3:0]      mem2Dcache_tag;

    // Arbiter side
    modport slave (
        input  Icache2mem_command, Icache2mem_addr,
        input  Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2Icache_response, mem2Icache_data, mem2Icache_tag,
        output mem2Dcache_response, mem2Dcache_data, mem2Dcache_tag
    );

    // Environment side (caches plus memory model)
    modport master (
        output Icache2mem_command, Icache2mem_addr,
        output Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2Icache_response, mem2Icache_data, mem2Icache_tag,
        input  mem2Dcache_response, mem2Dcache_data, mem2Dcache_tag
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache priority with icache anti-starvation,
// tag-based completion routing and per-requester outstanding load counts.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = 32
) (
    input  logic          clock,
    input  logic          reset,   // active low, asynchronous
    mem_arbiter_if.slave  bus,
    output logic [3:0]    icache_outstanding,
    output logic [3:0]    dcache_outstanding,
    output logic          tag_error
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
    localparam logic OwnIcache = 1'b0;
    localparam logic OwnDcache = 1'b1;

    logic [15:0]   valid_q, valid_d;
    logic [15:0]   owner_q, owner_d;
    logic [3:0]    icnt_q, icnt_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          tag_error_q, tag_error_d;

    logic i_req, d_req, grant_i, grant_d;
    logic accepted, load_acc, cpl_hit, cpl_miss, cpl_owner;
    logic inc_i, dec_i, inc_d, dec_d;

    // Grant decision, command muxing and response/completion routing.
    always_comb begin
        bus.proc2mem_command    = `BUS_NONE;
        bus.proc2mem_addr       = '0;
        bus.proc2mem_data       = '0;
        bus.mem2Icache_response = '0;
        bus.mem2Icache_data     = '0;
        bus.mem2Icache_tag      = '0;
        bus.mem2Dcache_response = '0;
        bus.mem2Dcache_data     = '0;
        bus.mem2Dcache_tag      = '0;

        // An icache store is not a legal request and is ignored.
        i_req = (bus.Icache2mem_command == `BUS_LOAD);
        d_req = (bus.Dcache2mem_command == `BUS_LOAD) ||
                (bus.Dcache2mem_command == `BUS_STORE);

        grant_i = i_req && (!d_req || (starve_q == StarveMax));
        grant_d = d_req && !grant_i;

        if (grant_i) begin
            bus.proc2mem_command    = `BUS_LOAD;
            bus.proc2mem_addr       = bus.Icache2mem_addr;
            bus.mem2Icache_response = bus.mem2proc_response;
        end else if (grant_d) begin
            bus.proc2mem_command    = bus.Dcache2mem_command;
            bus.proc2mem_addr       = bus.Dcache2mem_addr;
            bus.mem2Dcache_response = bus.mem2proc_response;
            if (bus.Dcache2mem_command == `BUS_STORE) begin
                bus.proc2mem_data = bus.Dcache2mem_data;
            end
        end

        accepted = (grant_i || grant_d) && (bus.mem2proc_response != 4'd0);
        load_acc = accepted && (bus.proc2mem_command == `BUS_LOAD);

        cpl_owner = owner_q[bus.mem2proc_tag];
        cpl_hit   = (bus.mem2proc_tag != 4'd0) && valid_q[bus.mem2proc_tag];
        cpl_miss  = (bus.mem2proc_tag != 4'd0) && !valid_q[bus.mem2proc_tag];

        if (cpl_hit && (cpl_owner == OwnIcache)) begin
            bus.mem2Icache_tag  = bus.mem2proc_tag;
            bus.mem2Icache_data = bus.mem2proc_data;
        end
        if (cpl_hit && (cpl_owner == OwnDcache)) begin
            bus.mem2Dcache_tag  = bus.mem2proc_tag;
            bus.mem2Dcache_data = bus.mem2proc_data;
        end

        // Nothing leaks to memory or the caches while held in reset.
        if (!reset) begin
            bus.proc2mem_command    = `BUS_NONE;
            bus.proc2mem_addr       = '0;
            bus.proc2mem_data       = '0;
            bus.mem2Icache_response = '0;
            bus.mem2Icache_data     = '0;
            bus.mem2Icache_tag      = '0;
            bus.mem2Dcache_response = '0;
            bus.mem2Dcache_data     = '0;
            bus.mem2Dcache_tag      = '0;
        end
    end

    // Next-state for owner table, outstanding counters, starvation and tag error.
    always_comb begin
        valid_d     = valid_q;
        owner_d     = owner_q;
        icnt_d      = icnt_q;
        dcnt_d      = dcnt_q;
        starve_d    = starve_q;
        tag_error_d = tag_error_q | cpl_miss;

        // Clear before set so a same-cycle re-accept of the tag wins.
        if (cpl_hit) begin
            valid_d[bus.mem2proc_tag] = 1'b0;
        end
        if (load_acc) begin
            valid_d[bus.mem2proc_response] = 1'b1;
            owner_d[bus.mem2proc_response] = grant_d ? OwnDcache : OwnIcache;
        end

        inc_i = load_acc && grant_i;
        inc_d = load_acc && grant_d;
        dec_i = cpl_hit && (cpl_owner == OwnIcache);
        dec_d = cpl_hit && (cpl_owner == OwnDcache);

        if (inc_i && !dec_i && (icnt_q != 4'd15)) begin
            icnt_d = icnt_q + 4'd1;
        end else if (dec_i && !inc_i && (icnt_q != 4'd0)) begin
            icnt_d = icnt_q - 4'd1;
        end
        if (inc_d && !dec_d && (dcnt_q != 4'd15)) begin
            dcnt_d = dcnt_q + 4'd1;
        end else if (dec_d && !inc_d && (dcnt_q != 4'd0)) begin
            dcnt_d = dcnt_q - 4'd1;
        end

        // Granted-but-rejected icache keeps its priority for the retry.
        if (!i_req) begin
            starve_d = '0;
        end else if (!grant_i) begin
            if (starve_q != StarveMax) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (accepted) begin
            starve_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            owner_q     <= '0;
            icnt_q      <= '0;
            dcnt_q      <= '0;
            starve_q    <= '0;
            tag_error_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            owner_q     <= owner_d;
            icnt_q      <= icnt_d;
            dcnt_q      <= dcnt_d;
            starve_q    <= starve_d;
            tag_error_q <= tag_error_d;
        end
    end

    // Status outputs follow state directly.
    always_comb begin
        icache_outstanding = icnt_q;
        dcache_outstanding = dcnt_q;
        tag_error          = tag_error_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus multi-cycle sequences.
module tb_mem_arbiter;

    localparam logic [1:0] N = 2'h0;
    localparam logic [1:0] L = 2'h1;
    localparam logic [1:0] S = 2'h2;

    logic       clock;
    logic       reset;
    logic [3:0] icache_outstanding;
    logic [3:0] dcache_outstanding;
    logic       tag_error;

    int vectors;
    int miscompares;

    mem_arbiter_if #(.XLEN(32)) bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (bus),
        .icache_outstanding (icache_outstanding),
        .dcache_outstanding (dcache_outstanding),
        .tag_error          (tag_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  ic;
        logic [31:0] ia;
        logic [1:0]  dc;
        logic [31:0] da;
        logic [63:0] dd;
        logic [3:0]  rsp;
        logic [3:0]  tg;
        logic [63:0] md;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_ir;
        logic [3:0]  e_dr;
        logic [3:0]  e_it;
        logic [3:0]  e_dt;
        logic [63:0] e_id;
        logic [63:0] e_dd;
        logic [3:0]  e_io;
        logic [3:0]  e_do;
        logic        e_te;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                         input logic [31:0] da, input logic [63:0] dd, input logic [3:0] rsp,
                         input logic [3:0] tg, input logic [63:0] md);
        bus.Icache2mem_command = ic;
        bus.Icache2mem_addr    = ia;
        bus.Dcache2mem_command = dc;
        bus.Dcache2mem_addr    = da;
        bus.Dcache2mem_data    = dd;
        bus.mem2proc_response  = rsp;
        bus.mem2proc_tag       = tg;
        bus.mem2proc_data      = md;
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic apply(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        drive(v.ic, v.ia, v.dc, v.da, v.dd, v.rsp, v.tg, v.md);
        vectors++;
        #1;
        chk({p, ".cmd"},   64'(bus.proc2mem_command),    64'(v.e_cmd));
        chk({p, ".addr"},  64'(bus.proc2mem_addr),       64'(v.e_addr));
        chk({p, ".data"},  bus.proc2mem_data,            v.e_data);
        chk({p, ".iresp"}, 64'(bus.mem2Icache_response), 64'(v.e_ir));
        chk({p, ".dresp"}, 64'(bus.mem2Dcache_response), 64'(v.e_dr));
        chk({p, ".itag"},  64'(bus.mem2Icache_tag),      64'(v.e_it));
        chk({p, ".dtag"},  64'(bus.mem2Dcache_tag),      64'(v.e_dt));
        chk({p, ".idata"}, bus.mem2Icache_data,          v.e_id);
        chk({p, ".ddata"}, bus.mem2Dcache_data,          v.e_dd);
        @(posedge clock);
        #1;
        chk({p, ".iout"},  64'(icache_outstanding), 64'(v.e_io));
        chk({p, ".dout"},  64'(dcache_outstanding), 64'(v.e_do));
        chk({p, ".terr"},  64'(tag_error),          64'(v.e_te));
        @(negedge clock);
    endtask

    // One cycle with both caches loading; checks which one reached memory.
    task automatic both_cycle(input string nm, input logic [3:0] rsp, input logic exp_icache);
        drive(L, 32'h1000, L, 32'h2000, 64'h0, rsp, 4'd0, 64'h0);
        vectors++;
        #1;
        chk({nm, ".addr"},  64'(bus.proc2mem_addr), exp_icache ? 64'h1000 : 64'h2000);
        chk({nm, ".iresp"}, 64'(bus.mem2Icache_response), exp_icache ? 64'(rsp) : 64'h0);
        chk({nm, ".dresp"}, 64'(bus.mem2Dcache_response), exp_icache ? 64'h0 : 64'(rsp));
        @(negedge clock);
    endtask

    localparam logic [63:0] DA = 64'h1122_3344_5566_7788;
    localparam logic [63:0] DE = 64'hCAFE_0000_0000_00EE;
    localparam logic [63:0] DF = 64'h0F0F_0F0F_F0F0_F0F0;

    initial begin
        vectors     = 0;
        miscompares = 0;

        //           ic ia        dc da        dd        rsp   tg    md
        //           cmd addr     data      ir    dr    it    dt    id   dd   io    do    te
        vecs[0] = '{N, 32'h0,   N, 32'h0,   64'h0,    4'd0, 4'd0, 64'h0,
                    N, 32'h0,   64'h0,    4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, 4'd0, 1'b0};
        vecs[1] = '{L, 32'h0,   N, 32'h0,   64'h0,    4'd3, 4'd0, 64'h0,
                    L, 32'h0,   64'h0,    4'd3, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd1, 4'd0, 1'b0};
        vecs[2] = '{N, 32'h0,   N, 32'h0,   64'h0,    4'd0, 4'd3, DA,
                    N, 32'h0,   64'h0,    4'd0, 4'd0, 4'd3, 4'd0, DA,    64'h0, 4'd0, 4'd0, 1'b0};
        vecs[3] = '{N, 32'h0,   S, 32'h100, 64'hDEAD, 4'd5, 4'd0, 64'h0,
                    S, 32'h100, 64'hDEAD, 4'd0, 4'd5, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, 4'd0, 1'b0};
        vecs[4] = '{N, 32'h0,   L, 32'h200, 64'hBEEF, 4'd2, 4'd0, 64'h0,
                    L, 32'h200, 64'h0,    4'd0, 4'd2, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, 4'd1, 1'b0};
        vecs[5] = '{L, 32'h40,  N, 32'h0,   64'h0,    4'd2, 4'd2, DE,
                    L, 32'h40,  64'h0,    4'd2, 4'd0, 4'd0, 4'd2, 64'h0, DE,    4'd1, 4'd0, 1'b0};
        vecs[6] = '{N, 32'h0,   N, 32'h0,   64'h0,    4'd0, 4'd2, DF,
                    N, 32'h0,   64'h0,    4'd0, 4'd0, 4'd2, 4'd0, DF,    64'h0, 4'd0, 4'd0, 1'b0};
        vecs[7] = '{N, 32'h0,   L, 32'h300, 64'h0,    4'd0, 4'd0, 64'h0,
                    L, 32'h300, 64'h0,    4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, 4'd0, 1'b0};
        vecs[8] = '{N, 32'h0,   N, 32'h0,   64'h0,    4'd0, 4'd7, 64'h77,
                    N, 32'h0,   64'h0,    4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, 4'd0, 1'b1};
        vecs[9] = '{S, 32'h500, N, 32'h0,   64'h0,    4'd6, 4'd0, 64'h0,
                    N, 32'h0,   64'h0,    4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, 4'd0, 1'b1};

        // Reset with live requests: all outputs must stay quiet.
        reset = 1'b0;
        drive(L, 32'h44, L, 32'h88, 64'h99, 4'd1, 4'd1, 64'h55);
        @(negedge clock);
        vectors++;
        chk("rst.cmd",   64'(bus.proc2mem_command), 64'h0);
        chk("rst.addr",  64'(bus.proc2mem_addr), 64'h0);
        chk("rst.iresp", 64'(bus.mem2Icache_response), 64'h0);
        chk("rst.dresp", 64'(bus.mem2Dcache_response), 64'h0);
        chk("rst.iout",  64'(icache_outstanding), 64'h0);
        chk("rst.terr",  64'(tag_error), 64'h0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(i, vecs[i]);
        end

        // Both load every cycle, all accepted: four dcache grants then one icache.
        for (int k = 1; k <= 10; k++) begin
            both_cycle($sformatf("starve%0d", k), 4'd1, (k % 5) == 0);
        end
        vectors++;
        chk("starve.iout", 64'(icache_outstanding), 64'd2);
        chk("starve.dout", 64'(dcache_outstanding), 64'd8);

        // Asynchronous reset mid-cycle with loads in flight.
        drive(L, 32'h1000, L, 32'h2000, 64'h0, 4'd1, 4'd0, 64'h0);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        chk("arst.iout", 64'(icache_outstanding), 64'h0);
        chk("arst.dout", 64'(dcache_outstanding), 64'h0);
        chk("arst.terr", 64'(tag_error), 64'h0);
        chk("arst.cmd",  64'(bus.proc2mem_command), 64'h0);
        chk("arst.iresp", 64'(bus.mem2Icache_response), 64'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Pre-reset tag comes back: dropped and flagged.
        drive(N, 32'h0, N, 32'h0, 64'h0, 4'd0, 4'd1, 64'h1234);
        vectors++;
        #1;
        chk("post.itag", 64'(bus.mem2Icache_tag), 64'h0);
        chk("post.dtag", 64'(bus.mem2Dcache_tag), 64'h0);
        chk("post.idata", bus.mem2Icache_data, 64'h0);
        @(posedge clock);
        #1;
        chk("post.terr", 64'(tag_error), 64'h1);
        @(negedge clock);

        // Icache granted at the limit but rejected keeps priority for the retry.
        for (int k = 1; k <= 4; k++) begin
            both_cycle($sformatf("hold%0d", k), 4'd3, 1'b0);
        end
        both_cycle("hold5", 4'd0, 1'b1);
        both_cycle("hold6", 4'd3, 1'b1);
        both_cycle("hold7", 4'd3, 1'b0);
        vectors++;
        chk("hold.iout", 64'(icache_outstanding), 64'd1);
        chk("hold.dout", 64'(dcache_outstanding), 64'd5);
        chk("hold.terr", 64'(tag_error), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
